// File: rtl/jpeg_rle_encoder.sv
// jpeg_rle_encoder
// ----------------
// Run-length / magnitude-category encoder for one 8x8 block of quantized
// coefficients arriving in zigzag order (64 per block, index 0 = DC).
// Each output symbol is (run, size, amp) with flags for DC and EOB, ready
// for the downstream Huffman stage. Runs of 16 zeros followed by a nonzero
// are emitted as ZRL symbols (run=15, size=0) before that nonzero.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : coefficient present on in_coef
//   in_ready   : encoder accepts in_coef this cycle
//   in_coef    : 12-bit signed quantized coefficient
//   out_valid  : symbol on out_* is valid
//   out_ready  : downstream consumes the symbol
//   out_run    : preceding zero count (0..15)
//   out_size   : magnitude category (0..11)
//   out_amp    : amplitude bits, LSB-aligned, upper bits zero
//   out_dc     : symbol is the DC term of a block
//   out_eob    : symbol is end-of-block
//
// Build option
//   JPEG_RLE_DC_DPCM_EN : when defined, the DC symbol carries the saturated
//   difference from the previous block's DC (predictor reset to 0); when
//   undefined the raw DC value is encoded and no predictor exists.

module jpeg_rle_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [11:0] in_coef,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_run,
  output logic [3:0]  out_size,
  output logic [10:0] out_amp,
  output logic        out_dc,
  output logic        out_eob
);

  localparam int DATA_W = 12;
  localparam int AMP_W  = DATA_W - 1;

  typedef enum logic [1:0] {
    ST_ACCEPT = 2'd0,
    ST_ZRL    = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  typedef struct packed {
    logic             dc;
    logic             eob;
    logic [3:0]       run;
    logic [3:0]       size;
    logic [AMP_W-1:0] amp;
  } sym_t;

  // -2048 has no 11-bit magnitude; fold it onto -2047.
  function automatic logic signed [DATA_W-1:0] clamp_coef(input logic signed [DATA_W-1:0] v);
    if (v == -12'sd2048) return -12'sd2047;
    return v;
  endfunction

  function automatic logic signed [DATA_W-1:0] sat_diff(input logic signed [DATA_W:0] d);
    if (d > 13'sd2047)  return 12'sd2047;
    if (d < -13'sd2047) return -12'sd2047;
    return d[DATA_W-1:0];
  endfunction

  // Bit length of |v|; v is never -2048 here.
  function automatic logic [3:0] cat_size(input logic signed [DATA_W-1:0] v);
    logic signed [DATA_W-1:0] a;
    logic [AMP_W-1:0]         mag;
    logic [3:0]               sz;
    a   = v[DATA_W-1] ? -v : v;
    mag = a[AMP_W-1:0];
    sz  = 4'd0;
    for (int i = 0; i < AMP_W; i++) begin
      if (mag[i]) sz = 4'(i + 1);
    end
    return sz;
  endfunction

  // Negative values are sent as (v-1) truncated to size bits (one's complement of |v|).
  function automatic logic [AMP_W-1:0] cat_amp(input logic signed [DATA_W-1:0] v,
                                               input logic [3:0]               sz);
    logic signed [DATA_W-1:0] vm1;
    logic [AMP_W-1:0]         mask;
    mask = AMP_W'((12'd1 << sz) - 12'd1);
    if (v[DATA_W-1]) begin
      vm1 = v - 12'sd1;
      return vm1[AMP_W-1:0] & mask;
    end
    return v[AMP_W-1:0];
  endfunction

  function automatic sym_t mk_sym(input logic dc, input logic eob, input logic [3:0] run,
                                  input logic [3:0] sz, input logic [AMP_W-1:0] amp);
    sym_t s;
    s.dc   = dc;
    s.eob  = eob;
    s.run  = run;
    s.size = sz;
    s.amp  = amp;
    return s;
  endfunction

  state_t     state_q, state_d;
  logic [5:0] idx_q, idx_d;
  logic [3:0] run_q, run_d;
  logic [1:0] zrl_q, zrl_d;
  logic       out_valid_q, out_valid_d;
  sym_t       out_sym_q, out_sym_d;
  sym_t       lat_sym_q, lat_sym_d;

  logic signed [DATA_W-1:0] coef_c;
  logic signed [DATA_W-1:0] dc_val;
  logic [3:0]               ac_size, dc_size;
  logic [AMP_W-1:0]         ac_amp, dc_amp;
  logic                     out_fire, out_free, in_fire;

  assign coef_c = clamp_coef(in_coef);

`ifdef JPEG_RLE_DC_DPCM_EN
  logic signed [DATA_W-1:0] pred_q, pred_d;
  logic signed [DATA_W:0]   dc_diff;
  assign dc_diff = {coef_c[DATA_W-1], coef_c} - {pred_q[DATA_W-1], pred_q};
  assign dc_val  = sat_diff(dc_diff);
`else
  assign dc_val  = coef_c;
`endif

  assign ac_size = cat_size(coef_c);
  assign ac_amp  = cat_amp(coef_c, ac_size);
  assign dc_size = cat_size(dc_val);
  assign dc_amp  = cat_amp(dc_val, dc_size);

  assign out_fire = out_valid_q && out_ready;
  assign out_free = !out_valid_q || out_ready;
  // Gated by rst_n so the bench-visible ready is low throughout reset.
  assign in_ready = rst_n && (state_q == ST_ACCEPT) && out_free;
  assign in_fire  = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    run_d       = run_q;
    zrl_d       = zrl_q;
    out_sym_d   = out_sym_q;
    lat_sym_d   = lat_sym_q;
    out_valid_d = out_valid_q && !out_fire;
`ifdef JPEG_RLE_DC_DPCM_EN
    pred_d      = pred_q;
`endif
    case (state_q)
      ST_ACCEPT: begin
        if (in_fire) begin
          idx_d = idx_q + 6'd1;
          if (idx_q == 6'd0) begin
            out_sym_d   = mk_sym(1'b1, 1'b0, 4'd0, dc_size, dc_amp);
            out_valid_d = 1'b1;
            run_d       = 4'd0;
            zrl_d       = 2'd0;
`ifdef JPEG_RLE_DC_DPCM_EN
            pred_d      = coef_c;
`endif
          end else if (coef_c == 12'sd0) begin
            if (idx_q == 6'd63) begin
              // Trailing zeros collapse into EOB; pending run/ZRL are dropped.
              out_sym_d   = mk_sym(1'b0, 1'b1, 4'd0, 4'd0, '0);
              out_valid_d = 1'b1;
              run_d       = 4'd0;
              zrl_d       = 2'd0;
            end else if (run_q == 4'd15) begin
              run_d = 4'd0;
              zrl_d = zrl_q + 2'd1;
            end else begin
              run_d = run_q + 4'd1;
            end
          end else if (zrl_q == 2'd0) begin
            out_sym_d   = mk_sym(1'b0, 1'b0, run_q, ac_size, ac_amp);
            out_valid_d = 1'b1;
            run_d       = 4'd0;
          end else begin
            // First ZRL goes out now; the nonzero waits in lat_sym until all ZRLs drain.
            lat_sym_d   = mk_sym(1'b0, 1'b0, run_q, ac_size, ac_amp);
            out_sym_d   = mk_sym(1'b0, 1'b0, 4'd15, 4'd0, '0);
            out_valid_d = 1'b1;
            run_d       = 4'd0;
            zrl_d       = zrl_q - 2'd1;
            state_d     = (zrl_q == 2'd1) ? ST_HOLD : ST_ZRL;
          end
        end
      end
      ST_ZRL: begin
        if (out_free) begin
          out_sym_d   = mk_sym(1'b0, 1'b0, 4'd15, 4'd0, '0);
          out_valid_d = 1'b1;
          zrl_d       = zrl_q - 2'd1;
          if (zrl_q == 2'd1) state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_free) begin
          out_sym_d   = lat_sym_q;
          out_valid_d = 1'b1;
          state_d     = ST_ACCEPT;
        end
      end
      default: state_d = ST_ACCEPT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ACCEPT;
      idx_q       <= 6'd0;
      run_q       <= 4'd0;
      zrl_q       <= 2'd0;
      out_valid_q <= 1'b0;
      out_sym_q   <= '0;
`ifdef JPEG_RLE_DC_DPCM_EN
      pred_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      run_q       <= run_d;
      zrl_q       <= zrl_d;
      out_valid_q <= out_valid_d;
      out_sym_q   <= out_sym_d;
`ifdef JPEG_RLE_DC_DPCM_EN
      pred_q      <= pred_d;
`endif
    end
  end

  // Latched nonzero symbol is pure data; it is always written before use.
  always_ff @(posedge clk) begin
    lat_sym_q <= lat_sym_d;
  end

  assign out_valid = out_valid_q;
  assign out_run   = out_sym_q.run;
  assign out_size  = out_sym_q.size;
  assign out_amp   = out_sym_q.amp;
  assign out_dc    = out_sym_q.dc;
  assign out_eob   = out_sym_q.eob;

endmodule

// File: tb/tb_jpeg_rle_encoder.sv
// Testbench for jpeg_rle_encoder: directed blocks with hand-computed symbol
// lists. Symbols are packed as {dc, eob, run[3:0], size[3:0], amp[10:0]}.

module tb_jpeg_rle_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] in_coef = 12'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [3:0]  out_run;
  logic [3:0]  out_size;
  logic [10:0] out_amp;
  logic        out_dc;
  logic        out_eob;

  jpeg_rle_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_coef   (in_coef),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_run   (out_run),
    .out_size  (out_size),
    .out_amp   (out_amp),
    .out_dc    (out_dc),
    .out_eob   (out_eob)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;
  int rd    = 0;
  int stall_cnt = 0;
  logic [20:0] got[$];
  logic [20:0] exp_q[$];
  logic signed [11:0] blk[64];

  function automatic logic [20:0] sym(input logic dc, input logic eob, input logic [3:0] run,
                                      input logic [3:0] sz, input logic [10:0] amp);
    return {dc, eob, run, sz, amp};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Collect every output transfer; count cycles where input is held off.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) got.push_back({out_dc, out_eob, out_run, out_size, out_amp});
      if (in_valid && !in_ready) stall_cnt++;
    end
  end

  task automatic send(input logic signed [11:0] c);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_coef  = c;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_blk(input int from, input int to);
    for (int i = from; i <= to; i++) send(blk[i]);
    in_valid = 1'b0;
  endtask

  task automatic zero_blk();
    for (int i = 0; i < 64; i++) blk[i] = 12'sd0;
  endtask

  task automatic drain();
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #2;
    chk("rst_outputs", {out_valid, out_dc, out_eob, out_run, out_size, out_amp}, 32'd0);
    chk("rst_in_ready", in_ready, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    rd = got.size();
  endtask

  task automatic expect_syms(input string tag);
    int have;
    have = got.size() - rd;
    chk({tag, "_count"}, have, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < have; i++)
      chk($sformatf("%s_sym%0d", tag, i), got[rd + i], exp_q[i]);
    rd = got.size();
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    #1;
    do_reset();

    // DC=5, all AC zero; also check 1-cycle latency of the DC symbol.
    zero_blk();
    blk[0] = 12'sd5;
    send(blk[0]);
    chk("lat_valid", out_valid, 1'b1);
    chk("lat_dc", out_dc, 1'b1);
    send_blk(1, 63);
    drain();
    exp_q.push_back(sym(1, 0, 0, 3, 5));
    exp_q.push_back(sym(0, 1, 0, 0, 0));
    expect_syms("dc5");

    // DC=-1, AC1=-3.
    do_reset();
    zero_blk();
    blk[0] = -12'sd1;
    blk[1] = -12'sd3;
    send_blk(0, 63);
    drain();
    exp_q.push_back(sym(1, 0, 0, 1, 0));
    exp_q.push_back(sym(0, 0, 0, 2, 0));
    exp_q.push_back(sym(0, 1, 0, 0, 0));
    expect_syms("ac1");

    // 40 zeros then a 1: two ZRLs, input stalled exactly 2 cycles.
    do_reset();
    zero_blk();
    blk[41] = 12'sd1;
    s0 = stall_cnt;
    send_blk(0, 63);
    drain();
    chk("zrl_stall", stall_cnt - s0, 2);
    exp_q.push_back(sym(1, 0, 0, 0, 0));
    exp_q.push_back(sym(0, 0, 15, 0, 0));
    exp_q.push_back(sym(0, 0, 15, 0, 0));
    exp_q.push_back(sym(0, 0, 8, 1, 1));
    exp_q.push_back(sym(0, 1, 0, 0, 0));
    expect_syms("zrl2");

    // Extremes, -2048 folding, three ZRLs into a nonzero last coefficient (no EOB).
    do_reset();
    zero_blk();
    blk[0]  = -12'sd2048;
    blk[1]  = 12'sd2047;
    blk[3]  = -12'sd2048;
    blk[4]  = 12'sd1;
    blk[5]  = -12'sd1;
    blk[6]  = 12'sd255;
    blk[63] = -12'sd6;
    send_blk(0, 63);
    drain();
    exp_q.push_back(sym(1, 0, 0, 11, 11'd0));
    exp_q.push_back(sym(0, 0, 0, 11, 11'd2047));
    exp_q.push_back(sym(0, 0, 1, 11, 11'd0));
    exp_q.push_back(sym(0, 0, 0, 1, 1));
    exp_q.push_back(sym(0, 0, 0, 1, 0));
    exp_q.push_back(sym(0, 0, 0, 8, 11'd255));
    exp_q.push_back(sym(0, 0, 15, 0, 0));
    exp_q.push_back(sym(0, 0, 15, 0, 0));
    exp_q.push_back(sym(0, 0, 15, 0, 0));
    exp_q.push_back(sym(0, 0, 8, 3, 1));
    expect_syms("edge");

    // Backpressure: out_ready low 5 cycles with the DC symbol pending.
    do_reset();
    zero_blk();
    blk[0] = 12'sd5;
    blk[1] = 12'sd3;
    out_ready = 1'b0;
    send(blk[0]);
    in_valid = 1'b1;
    in_coef  = blk[1];
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_sym", {out_dc, out_eob, out_run, out_size, out_amp}, sym(1, 0, 0, 3, 5));
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_in_ready", in_ready, 1'b0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send_blk(1, 63);
    drain();
    exp_q.push_back(sym(1, 0, 0, 3, 5));
    exp_q.push_back(sym(0, 0, 0, 2, 3));
    exp_q.push_back(sym(0, 1, 0, 0, 0));
    expect_syms("bp");

    // Two consecutive blocks, DC=10 then DC=7.
    do_reset();
    zero_blk();
    blk[0] = 12'sd10;
    send_blk(0, 63);
    blk[0] = 12'sd7;
    send_blk(0, 63);
    drain();
    exp_q.push_back(sym(1, 0, 0, 4, 10));
    exp_q.push_back(sym(0, 1, 0, 0, 0));
`ifdef JPEG_RLE_DC_DPCM_EN
    exp_q.push_back(sym(1, 0, 0, 2, 0));
`else
    exp_q.push_back(sym(1, 0, 0, 3, 7));
`endif
    exp_q.push_back(sym(0, 1, 0, 0, 0));
    expect_syms("dc2");

    // Reset after index 20, then a fresh block starts at DC.
    do_reset();
    zero_blk();
    blk[0] = 12'sd9;
    blk[5] = 12'sd4;
    send_blk(0, 20);
    do_reset();
    zero_blk();
    blk[0] = 12'sd6;
    send_blk(0, 63);
    drain();
    exp_q.push_back(sym(1, 0, 0, 3, 6));
    exp_q.push_back(sym(0, 1, 0, 0, 0));
    expect_syms("midrst");

    // Reset while a ZRL is pending and the nonzero is latched.
    do_reset();
    zero_blk();
    blk[0]  = 12'sd1;
    blk[20] = 12'sd5;
    send_blk(0, 20);
    out_ready = 1'b0;
    #2;
    chk("zrl_pending_valid", out_valid, 1'b1);
    chk("zrl_pending_in_ready", in_ready, 1'b0);
    @(posedge clk);
    #1;
    do_reset();
    out_ready = 1'b1;
    zero_blk();
    blk[0] = -12'sd5;
    send_blk(0, 63);
    drain();
    exp_q.push_back(sym(1, 0, 0, 3, 2));
    exp_q.push_back(sym(0, 1, 0, 0, 0));
    expect_syms("zrlrst");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/jpeg_rle_encoder.md
JPEG_RLE_ENCODER -- requirements
Module: jpeg_rle_encoder

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 in_valid  input  1  quantized coefficient available (zigzag order, 64 per block).
REQ-004 in_ready  output  1  block accepts in_coef this cycle.
REQ-005 in_coef  input  12  signed two's-complement quantized coefficient; index 0 is DC.
REQ-006 out_valid  output  1  symbol held on out_* is valid.
REQ-007 out_ready  input  1  downstream (Huffman stage) consumes symbol.
REQ-008 out_run  output  4  preceding zero count (0..15).
REQ-009 out_size  output  4  magnitude category (0..11).
REQ-010 out_amp  output  11  amplitude bits, LSB-aligned, upper bits zero.
REQ-011 out_dc  output  1  symbol is the DC term of a block.
REQ-012 out_eob  output  1  symbol marks end of block (run=0,size=0).

Function
REQ-013 Input transfer occurs when in_valid && in_ready; output transfer occurs when out_valid && out_ready.
REQ-014 A 6-bit index counter counts accepted coefficients and wraps from 63 to 0; index 63 marks the block end.
REQ-015 States: ACCEPT, ZRL, HOLD; reset enters ACCEPT.
REQ-016 in_ready = (state==ACCEPT) && (!out_valid || out_ready).
REQ-017 Index 0: emit one symbol with out_dc=1, run=0, and size/amp of the DC value (see REQ-030); run and zrl_cnt clear.
REQ-018 AC zero, index 1..62: run increments; at run==15 plus another zero, run clears to 0 and the 2-bit zrl_cnt increments; no symbol emitted; in_ready stays high.
REQ-019 AC nonzero with zrl_cnt==0: emit (run, size, amp) one cycle after acceptance, then clear run.
REQ-020 AC nonzero with zrl_cnt>0: latch coefficient, go to ZRL; emit zrl_cnt symbols (run=15, size=0, amp=0), one per output transfer; then go to HOLD, emit the latched symbol, and return to ACCEPT; in_ready=0 throughout.
REQ-021 Index 63 zero: emit EOB (out_eob=1); discard pending run and zrl_cnt.
REQ-022 Index 63 nonzero: emit it per REQ-019/020; no EOB follows.
REQ-023 size = bit length of |v| (0 for v==0); amp = v if v>0, else (v-1) masked to size bits.
REQ-024 in_coef = -2048 is treated as -2047 (size 11).
REQ-025 The output register holds while out_valid && !out_ready; accepting new input in the same cycle as an output transfer is permitted, giving 1 symbol/cycle throughput.
REQ-026 A symbol is registered: latency from input acceptance to out_valid is exactly 1 cycle when not stalled.

Reset
REQ-027 While rst_n=0: out_valid=0, out_run=0, out_size=0, out_amp=0, out_dc=0, out_eob=0, index=0, run=0, zrl_cnt=0, DC predictor=0, state=ACCEPT.
REQ-028 A reset mid-block or mid-ZRL discards all partial state; the first coefficient after release is index 0 (DC).
REQ-029 in_ready is 0 during reset and 1 in the first cycle after release.

Configuration
REQ-030 JPEG_RLE_DC_DPCM_EN defined: the DC symbol encodes diff = DC - pred, computed in 13 bits and saturated to ±2047; pred updates to the current DC on each DC acceptance; pred resets to 0.
REQ-031 JPEG_RLE_DC_DPCM_EN undefined: the DC symbol encodes the raw DC value and no predictor register exists.

Verification
REQ-032 Block DC=5, AC all 0, out_ready=1 -> exactly two symbols: DC(size3, amp5), then EOB.
REQ-033 Block with AC[1]=-3 and the rest zero -> DC; then (run0, size2, amp2'b00); then EOB.
REQ-034 AC[1..40]=0, AC[41]=1, rest zero -> DC, ZRL, ZRL, (run8, size1, amp1), EOB; in_ready low for 2 cycles during emission.
REQ-035 out_ready held low for 5 cycles while a symbol is pending -> out_* stable, in_ready=0, no symbol lost or duplicated.
REQ-036 With DPCM enabled, two blocks with DC=10 then DC=7 -> DC symbols diff=10 (size4, amp10) then diff=-3 (size2, amp2'b00); without DPCM -> size4 amp10, then size3 amp7.
REQ-037 rst_n pulsed low after index 20 -> outputs cleared; the next input is encoded as DC with out_dc=1.
